dcache_wb_buf: RTL and testbench

DCACHE_WB_BUF -- requirements
Module: dcache_wb_buf

---
 rtl/dcache_wb_buf_pkg.sv | 23 ++
 rtl/dcache_wb_buf_addr_match.sv | 33 +++
 rtl/dcache_wb_buf.sv | 155 +++++++++++++++
 tb/tb_dcache_wb_buf.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_wb_buf_pkg.sv
// Shared definitions for the dcache write-back buffer: request/data types, FSM states, default depth.
package dcache_wb_buf_pkg;

    localparam int WB_BUF_N_ENTRIES = 4;
    localparam int BLOCK_ADDR_W     = 16;
    localparam int BLOCK_DATA_W     = 64;

    typedef enum logic {
        REQ_READ  = 1'b0,
        REQ_WRITE = 1'b1
    } req_type_t;

    typedef logic [BLOCK_DATA_W-1:0] block_data_t;
    typedef logic [BLOCK_ADDR_W-1:0] main_mem_block_addr_t;

    typedef enum logic [1:0] {
        WB_IDLE,
        WB_FWD,
        WB_RD_ISSUE,
        WB_RD_WAIT
    } wb_state_t;

endpackage

// File: rtl/dcache_wb_buf_addr_match.sv
// Youngest-match address search across the write-buffer entries, walking oldest to youngest from head.
module wb_addr_match
    import dcache_wb_buf_pkg::*;
#(
    parameter int N_ENTRIES = WB_BUF_N_ENTRIES
) (
    input  logic [N_ENTRIES-1:0]         entry_valid,
    input  main_mem_block_addr_t         entry_addr [N_ENTRIES],
    input  logic [$clog2(N_ENTRIES)-1:0] head,
    input  main_mem_block_addr_t         query_addr,
    output logic                         hit,
    output logic [$clog2(N_ENTRIES)-1:0] hit_idx
);

    localparam int PTR_W = $clog2(N_ENTRIES);

    logic [PTR_W-1:0] idx;

    // Later (younger) matches overwrite earlier ones; pointer arithmetic wraps on power-of-two depth.
    always_comb begin
        hit     = 1'b0;
        hit_idx = head;
        idx     = '0;
        for (int k = 0; k < N_ENTRIES; k++) begin
            idx = head + PTR_W'(k);
            if (entry_valid[idx] && (entry_addr[idx] == query_addr)) begin
                hit     = 1'b1;
                hit_idx = idx;
            end
        end
    end

endmodule

// File: rtl/dcache_wb_buf.sv
// Dcache write-back buffer: circular FIFO of write-backs with read forwarding and a read-miss path to mem_ctrl.
// Optional write coalescing into existing entries is enabled by defining DCACHE_WB_BUF_COALESCE_EN.
module dcache_wb_buf
    import dcache_wb_buf_pkg::*;
#(
    parameter int N_ENTRIES = WB_BUF_N_ENTRIES
) (
    input  logic                       clk,
    input  logic                       rst_aH,
    input  logic                       dc_req_valid,
    input  req_type_t                  dc_req_type,
    input  main_mem_block_addr_t       dc_req_block_addr,
    input  block_data_t                dc_req_block_data,
    output logic                       dc_req_ready,
    output logic                       dc_resp_valid,
    output block_data_t                dc_resp_block_data,
    output logic                       mc_req_valid,
    output req_type_t                  mc_req_type,
    output main_mem_block_addr_t       mc_req_block_addr,
    output block_data_t                mc_req_block_data,
    input  logic                       mc_req_ready,
    input  logic                       mc_resp_valid,
    input  block_data_t                mc_resp_block_data,
    output logic [$clog2(N_ENTRIES):0] wb_count,
    output logic                       wb_empty
);

    localparam int PTR_W = $clog2(N_ENTRIES);
    localparam int CNT_W = PTR_W + 1;

    wb_state_t            state, state_nxt;
    logic [PTR_W-1:0]     head, tail;
    logic [CNT_W-1:0]     count;
    logic [N_ENTRIES-1:0] valid;
    main_mem_block_addr_t ent_addr [N_ENTRIES];
    block_data_t          ent_data [N_ENTRIES];
    main_mem_block_addr_t rd_addr;
    block_data_t          fwd_data;

    logic             hit;
    logic [PTR_W-1:0] hit_idx;
    logic             full, req_is_wr, head_drain, drain_pop, coalesce;
    logic             rd_accept, wr_accept, push;

    wb_addr_match #(.N_ENTRIES(N_ENTRIES)) u_match (
        .entry_valid (valid),
        .entry_addr  (ent_addr),
        .head        (head),
        .query_addr  (dc_req_block_addr),
        .hit         (hit),
        .hit_idx     (hit_idx)
    );

    assign full       = (count == CNT_W'(N_ENTRIES));
    assign req_is_wr  = (dc_req_type == REQ_WRITE);
    // Head is offered to mem_ctrl whenever the read path does not own the request channel.
    assign head_drain = (count != '0) && ((state == WB_IDLE) || (state == WB_FWD));
    assign drain_pop  = !rst_aH && head_drain && mc_req_ready;

`ifdef DCACHE_WB_BUF_COALESCE_EN
    assign coalesce = hit && !(drain_pop && (hit_idx == head));
`else
    assign coalesce = 1'b0;
`endif

    assign dc_req_ready = !rst_aH && (req_is_wr ? (!full || coalesce) : (state == WB_IDLE));
    assign rd_accept    = dc_req_valid && dc_req_ready && !req_is_wr;
    assign wr_accept    = dc_req_valid && dc_req_ready && req_is_wr;
    assign push         = wr_accept && !coalesce;

    assign wb_count = count;
    assign wb_empty = (count == '0);

    always_ff @(posedge clk) begin
        if (rst_aH) begin
            state <= WB_IDLE;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
        end else begin
            state <= state_nxt;
            if (push) begin
                tail        <= tail + 1'b1;
                valid[tail] <= 1'b1;
            end
            if (drain_pop) begin
                head        <= head + 1'b1;
                valid[head] <= 1'b0;
            end
            count <= count + CNT_W'(push) - CNT_W'(drain_pop);
        end
    end

    // Payload storage carries no reset; occupancy is tracked solely by valid/count.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr[tail] <= dc_req_block_addr;
            ent_data[tail] <= dc_req_block_data;
        end
        if (wr_accept && coalesce) begin
            ent_data[hit_idx] <= dc_req_block_data;
        end
        if (rd_accept) begin
            rd_addr <= dc_req_block_addr;
            if (hit) begin
                fwd_data <= ent_data[hit_idx];
            end
        end
    end

    always_comb begin
        state_nxt          = state;
        dc_resp_valid      = 1'b0;
        dc_resp_block_data = fwd_data;
        mc_req_valid       = 1'b0;
        mc_req_type        = REQ_WRITE;
        mc_req_block_addr  = ent_addr[head];
        mc_req_block_data  = ent_data[head];
        if (!rst_aH) begin
            case (state)
                WB_IDLE: begin
                    if (dc_req_valid && !req_is_wr) begin
                        state_nxt = hit ? WB_FWD : WB_RD_ISSUE;
                    end
                end
                WB_FWD: begin
                    dc_resp_valid = 1'b1;
                    state_nxt     = WB_IDLE;
                end
                WB_RD_ISSUE: begin
                    mc_req_valid      = 1'b1;
                    mc_req_type       = REQ_READ;
                    mc_req_block_addr = rd_addr;
                    mc_req_block_data = '0;
                    if (mc_req_ready) begin
                        state_nxt = WB_RD_WAIT;
                    end
                end
                WB_RD_WAIT: begin
                    dc_resp_valid      = mc_resp_valid;
                    dc_resp_block_data = mc_resp_block_data;
                    if (mc_resp_valid) begin
                        state_nxt = WB_IDLE;
                    end
                end
                default: state_nxt = WB_IDLE;
            endcase
            if (head_drain) begin
                mc_req_valid = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dcache_wb_buf.sv
// Self-checking bench for dcache_wb_buf: directed scenarios followed by random traffic against a queue-based model.
module tb_dcache_wb_buf;
    import dcache_wb_buf_pkg::*;

    localparam int N = WB_BUF_N_ENTRIES;

    typedef struct {
        main_mem_block_addr_t a;
        block_data_t          d;
    } ent_t;

    logic                 clk;
    logic                 rst_aH;
    logic                 dc_req_valid;
    req_type_t            dc_req_type;
    main_mem_block_addr_t dc_req_block_addr;
    block_data_t          dc_req_block_data;
    logic                 dc_req_ready;
    logic                 dc_resp_valid;
    block_data_t          dc_resp_block_data;
    logic                 mc_req_valid;
    req_type_t            mc_req_type;
    main_mem_block_addr_t mc_req_block_addr;
    block_data_t          mc_req_block_data;
    logic                 mc_req_ready;
    logic                 mc_resp_valid;
    block_data_t          mc_resp_block_data;
    logic [$clog2(N):0]   wb_count;
    logic                 wb_empty;

    int n_cmp = 0;
    int n_bad = 0;

    ent_t                 q[$];
    block_data_t          mem[main_mem_block_addr_t];
    logic                 fwd_due, miss_issue, miss_wait, resp_hold;
    block_data_t          fwd_d;
    main_mem_block_addr_t miss_addr;
    int                   wait_cnt, resp_lat, next_lat;

    dcache_wb_buf #(.N_ENTRIES(N)) dut (
        .clk                (clk),
        .rst_aH             (rst_aH),
        .dc_req_valid       (dc_req_valid),
        .dc_req_type        (dc_req_type),
        .dc_req_block_addr  (dc_req_block_addr),
        .dc_req_block_data  (dc_req_block_data),
        .dc_req_ready       (dc_req_ready),
        .dc_resp_valid      (dc_resp_valid),
        .dc_resp_block_data (dc_resp_block_data),
        .mc_req_valid       (mc_req_valid),
        .mc_req_type        (mc_req_type),
        .mc_req_block_addr  (mc_req_block_addr),
        .mc_req_block_data  (mc_req_block_data),
        .mc_req_ready       (mc_req_ready),
        .mc_resp_valid      (mc_resp_valid),
        .mc_resp_block_data (mc_resp_block_data),
        .wb_count           (wb_count),
        .wb_empty           (wb_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic block_data_t mem_val(main_mem_block_addr_t a);
        if (mem.exists(a)) return mem[a];
        return {48'hC0DE_0000_0000, a};
    endfunction

    function automatic int youngest(main_mem_block_addr_t a);
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].a == a) return i;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive memory response, check outputs at negedge against the model, advance the model.
    task automatic step();
        logic                 busy, drain, coal, pop;
        logic                 exp_ready, exp_mv, exp_rv;
        req_type_t            exp_mt;
        main_mem_block_addr_t exp_ma;
        block_data_t          exp_md, exp_rd;
        int                   hidx;
        ent_t                 e;

        if (miss_wait && !resp_hold && (wait_cnt >= resp_lat)) begin
            mc_resp_valid      = 1'b1;
            mc_resp_block_data = mem_val(miss_addr);
        end else begin
            mc_resp_valid      = 1'b0;
            mc_resp_block_data = {$urandom, $urandom};
        end

        @(negedge clk);
        busy  = fwd_due || miss_issue || miss_wait;
        drain = (q.size() > 0) && !miss_issue && !miss_wait;
        hidx  = youngest(dc_req_block_addr);
        coal  = 1'b0;
`ifdef DCACHE_WB_BUF_COALESCE_EN
        coal  = (hidx >= 0) && !((hidx == 0) && drain && mc_req_ready);
`endif
        exp_ready = 1'b0;
        exp_mv    = 1'b0;
        exp_mt    = REQ_WRITE;
        exp_ma    = '0;
        exp_md    = '0;
        exp_rv    = 1'b0;
        exp_rd    = '0;
        if (!rst_aH) begin
            exp_ready = (dc_req_type == REQ_WRITE) ? ((q.size() < N) || coal) : !busy;
            if (miss_issue) begin
                exp_mv = 1'b1;
                exp_mt = REQ_READ;
                exp_ma = miss_addr;
            end else if (drain) begin
                exp_mv = 1'b1;
                exp_ma = q[0].a;
                exp_md = q[0].d;
            end
            if (fwd_due) begin
                exp_rv = 1'b1;
                exp_rd = fwd_d;
            end else if (miss_wait && mc_resp_valid) begin
                exp_rv = 1'b1;
                exp_rd = mem_val(miss_addr);
            end
        end

        if (dc_req_valid || rst_aH) chk("dc_req_ready", dc_req_ready, exp_ready);
        chk("mc_req_valid", mc_req_valid, exp_mv);
        if (exp_mv) begin
            chk("mc_req_type", mc_req_type, exp_mt);
            chk("mc_req_addr", mc_req_block_addr, exp_ma);
            if (exp_mt == REQ_WRITE) chk("mc_req_data", mc_req_block_data, exp_md);
        end
        chk("dc_resp_valid", dc_resp_valid, exp_rv);
        if (exp_rv) chk("dc_resp_data", dc_resp_block_data, exp_rd);
        chk("wb_count", wb_count, 64'(q.size()));
        chk("wb_empty", wb_empty, q.size() == 0);

        if (rst_aH) begin
            q.delete();
            fwd_due    = 1'b0;
            miss_issue = 1'b0;
            miss_wait  = 1'b0;
        end else begin
            pop = exp_mv && (exp_mt == REQ_WRITE) && mc_req_ready;
            if (miss_wait) begin
                if (mc_resp_valid) miss_wait = 1'b0;
                else wait_cnt++;
            end
            if (miss_issue && mc_req_ready) begin
                miss_issue = 1'b0;
                miss_wait  = 1'b1;
                wait_cnt   = 0;
                resp_lat   = next_lat;
            end
            fwd_due = 1'b0;
            if (dc_req_valid && exp_ready) begin
                if (dc_req_type == REQ_WRITE) begin
                    if (coal) begin
                        e       = q[hidx];
                        e.d     = dc_req_block_data;
                        q[hidx] = e;
                    end else begin
                        e.a = dc_req_block_addr;
                        e.d = dc_req_block_data;
                        q.push_back(e);
                    end
                end else if (hidx >= 0) begin
                    fwd_due = 1'b1;
                    fwd_d   = q[hidx].d;
                end else begin
                    miss_issue = 1'b1;
                    miss_addr  = dc_req_block_addr;
                end
            end
            if (pop) begin
                mem[q[0].a] = q[0].d;
                void'(q.pop_front());
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input main_mem_block_addr_t a, input block_data_t d);
        dc_req_valid      = 1'b1;
        dc_req_type       = REQ_WRITE;
        dc_req_block_addr = a;
        dc_req_block_data = d;
        step();
        dc_req_valid      = 1'b0;
        dc_req_type       = REQ_READ;
    endtask

    task automatic rd(input main_mem_block_addr_t a);
        dc_req_valid      = 1'b1;
        dc_req_type       = REQ_READ;
        dc_req_block_addr = a;
        step();
        dc_req_valid      = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drain_all(input string tag);
        mc_req_ready = 1'b1;
        for (int i = 0; i < 60 && (q.size() > 0 || fwd_due || miss_issue || miss_wait); i++) step();
        step();
        chk(tag, wb_empty, 1'b1);
    endtask

    initial begin
        rst_aH             = 1'b1;
        dc_req_valid       = 1'b0;
        dc_req_type        = REQ_READ;
        dc_req_block_addr  = '0;
        dc_req_block_data  = '0;
        mc_req_ready       = 1'b0;
        mc_resp_valid      = 1'b0;
        mc_resp_block_data = '0;
        fwd_due            = 1'b0;
        miss_issue         = 1'b0;
        miss_wait          = 1'b0;
        resp_hold          = 1'b0;
        wait_cnt           = 0;
        resp_lat           = 0;
        next_lat           = 0;
        fwd_d              = '0;
        miss_addr          = '0;

        @(posedge clk);
        #1;
        idle(2);
        rst_aH = 1'b0;
        idle(1);

        // Write then read the same block: forwarded from the buffer, no memory read.
        wr(16'h0010, 64'hD0D0_0000_0000_00D0);
        rd(16'h0010);
        idle(3);
        drain_all("empty_after_fwd");

        // Read miss on an empty buffer goes to memory.
        next_lat = 0;
        rd(16'h0020);
        idle(4);
        next_lat = 2;
        rd(16'h0021);
        idle(6);

        // Fill while mem_ctrl stalls; fifth write refused; drain in order.
        mc_req_ready = 1'b0;
        for (int i = 1; i <= 4; i++) wr(16'(i), 64'hA000_0000_0000_0000 | 64'(i));
        chk("full_count", wb_count, 4);
        wr(16'h0005, 64'hBAD);
        drain_all("empty_after_full");

        // Six write/drain rounds to wrap the pointers.
        mc_req_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr(16'h0030 + 16'(i), {$urandom, $urandom});
            idle(1);
        end
        drain_all("empty_after_wrap");

        // Two writes to one address while stalled.
        mc_req_ready = 1'b0;
        wr(16'h0005, 64'hAAAA_AAAA_AAAA_AAAA);
        wr(16'h0005, 64'hBBBB_BBBB_BBBB_BBBB);
`ifdef DCACHE_WB_BUF_COALESCE_EN
        chk("dup_write_count", wb_count, 1);
`else
        chk("dup_write_count", wb_count, 2);
`endif
        drain_all("empty_after_dup");

        // Reset while a read is waiting on memory with three buffered writes.
        mc_req_ready = 1'b0;
        wr(16'h0040, 64'h40);
        wr(16'h0041, 64'h41);
        wr(16'h0042, 64'h42);
        resp_hold = 1'b1;
        rd(16'h0099);
        mc_req_ready = 1'b1;
        idle(1);
        mc_req_ready = 1'b0;
        idle(1);
        chk("pre_rst_count", wb_count, 3);
        rst_aH = 1'b1;
        idle(1);
        rst_aH = 1'b0;
        chk("post_rst_count", wb_count, 0);
        chk("post_rst_resp", dc_resp_valid, 1'b0);
        resp_hold = 1'b0;
        idle(2);

        // Random mixed traffic on a small address set.
        for (int c = 0; c < 600; c++) begin
            dc_req_valid      = ($urandom_range(0, 2) != 0);
            dc_req_type       = ($urandom_range(0, 1) != 0) ? REQ_WRITE : REQ_READ;
            dc_req_block_addr = 16'($urandom_range(0, 5));
            dc_req_block_data = {$urandom, $urandom};
            mc_req_ready      = ($urandom_range(0, 3) != 0);
            next_lat          = $urandom_range(0, 3);
            step();
        end
        dc_req_valid = 1'b0;
        drain_all("empty_after_random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
